data_memory: RTL and testbench

- Word-addressed data RAM used by the pipeline's memory stage for load/store instructions.
- Combinational read port: the memory stage captures RD into its M/W pipeline register on the same clock edge.
- Single synchronous write port.
- Asynchronous clear of the full array on reset.

---
 rtl/data_memory_pkg.sv | 11 +
 rtl/data_memory.sv | 39 +++
 tb/tb_data_memory.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared constants for the pipeline data memory: word width and default depth.
package data_memory_pkg;

  localparam int WORD_SIZE      = 32;
  localparam int MEM_DEPTH_LOG2 = 6;

  function automatic int mem_words(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM for the memory stage: combinational read, synchronous
// full-word write, whole-array clear on asynchronous reset.
module data_memory #(
  parameter int WORD_SIZE  = data_memory_pkg::WORD_SIZE,
  parameter int DEPTH_LOG2 = data_memory_pkg::MEM_DEPTH_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 WE,
  input  logic [WORD_SIZE-1:0] WD,
  input  logic [WORD_SIZE-1:0] A,
  output logic [WORD_SIZE-1:0] RD
);
  import data_memory_pkg::*;

  localparam int DEPTH = mem_words(DEPTH_LOG2);

  logic [WORD_SIZE-1:0]  r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_unused_addr_bits;

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  assign w_idx              = A[DEPTH_LOG2+1:2];
  assign w_unused_addr_bits = ^{A[WORD_SIZE-1:DEPTH_LOG2+2], A[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (WE) begin
      r_mem[w_idx] <= WD;
    end
  end

  // The array is already zero during reset; gating keeps RD clean from the first instant.
  assign RD = rst ? '0 : r_mem[w_idx];

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed table, reset corner cases and
// randomized traffic checked against a word-array model.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] A;
  logic [31:0] RD;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [64];

  data_memory #(.WORD_SIZE(32), .DEPTH_LOG2(6)) dut (
    .clk(clk), .rst(rst), .WE(WE), .WD(WD), .A(A), .RD(RD)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
  } vec_t;

  function automatic int widx(input logic [31:0] addr);
    int unsigned u;
    u = addr;
    return int'((u / 4) % 64);
  endfunction

  task automatic check(input string name, input logic [31:0] exp);
    checks++;
    if (RD !== exp) begin
      errors++;
      $display("FAIL %s: A=0x%08h RD=0x%08h required=0x%08h", name, A, RD, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = 32'h0;
  endtask

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h14,       32'h0,        32'h0,        32'h0};
    vecs[3]  = '{1'b1, 32'h20,       32'h11111111, 32'h0,        32'h11111111};
    vecs[4]  = '{1'b1, 32'h20,       32'h22222222, 32'h11111111, 32'h22222222};
    vecs[5]  = '{1'b1, 32'h08,       32'hCAFEBABE, 32'h0,        32'hCAFEBABE};
    vecs[6]  = '{1'b0, 32'h0B,       32'h0,        32'hCAFEBABE, 32'hCAFEBABE};
    vecs[7]  = '{1'b0, 32'h108,      32'h0,        32'hCAFEBABE, 32'hCAFEBABE};
    vecs[8]  = '{1'b0, 32'h30,       32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 32'h30,       32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 32'h30,       32'hFFFFFFFF, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 32'h13,       32'h12345678, 32'hDEADBEEF, 32'h12345678};
    vecs[12] = '{1'b0, 32'hFFFFFF10, 32'h0,        32'h12345678, 32'h12345678};

    rst = 1'b1; WE = 1'b0; WD = 32'h0; A = 32'h0;
    clear_model();

    // Reset held: RD must read zero regardless of A, writes blocked
    repeat (2) @(posedge clk);
    @(negedge clk);
    WE = 1'b1; WD = 32'hA5A5A5A5; A = 32'h44;
    @(posedge clk); #1;
    check("rd_during_reset", 32'h0);
    @(negedge clk);
    WE = 1'b0;
    rst = 1'b0;
    #1;
    check("write_blocked_in_reset", 32'h0);

    // Reset clear sweep
    for (int i = 0; i < 64; i++) begin
      A = 32'(i * 4);
      #1;
      check("reset_clear", 32'h0);
    end
    $display("sweep 0x00..0xFC after reset done");

    // Directed table
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      WE = vecs[i].we; A = vecs[i].a; WD = vecs[i].wd;
      #1;
      check("table_pre_edge", vecs[i].exp_pre);
      @(posedge clk); #1;
      check("table_post_edge", vecs[i].exp_post);
      if (vecs[i].we) model[widx(vecs[i].a)] = vecs[i].wd;
      $display("vec %0d we=%0b A=0x%08h WD=0x%08h RD=0x%08h", i, vecs[i].we, vecs[i].a, vecs[i].wd, RD);
    end

    // Async reset pulse between clock edges
    @(negedge clk);
    WE = 1'b0; A = 32'h10;
    #1;
    check("pre_async_reset", model[widx(32'h10)]);
    rst = 1'b1;
    #1;
    check("async_clear_0x10", 32'h0);
    A = 32'h20;
    #1;
    check("async_clear_0x20", 32'h0);
    clear_model();
    WE = 1'b1; A = 32'h40; WD = 32'hAAAAAAAA;
    @(posedge clk); #1;
    @(negedge clk);
    WE = 1'b0; rst = 1'b0;
    #1;
    check("write_ignored_in_reset", 32'h0);
    A = 32'h20;
    #1;
    check("stays_clear_after_release", 32'h0);
    $display("async reset pulse done");

    // Write right at the first edge after release
    @(negedge clk);
    WE = 1'b1; A = 32'h40; WD = 32'h55555555;
    @(posedge clk); #1;
    check("first_write_after_release", 32'h55555555);
    model[widx(32'h40)] = 32'h55555555;
    $display("write after release A=0x40 RD=0x%08h", RD);

    // Reset coincident with a write edge: word must end up zero
    @(negedge clk);
    WE = 1'b1; A = 32'h50; WD = 32'h0BADF00D;
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("reset_wins_at_edge", 32'h0);
    clear_model();
    @(negedge clk);
    WE = 1'b0; rst = 1'b0;
    #1;
    check("reset_wins_after_release", 32'h0);
    A = 32'h40;
    #1;
    check("coincident_reset_cleared_0x40", 32'h0);
    $display("coincident reset/write done");

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      WE = ($urandom_range(0, 2) != 0);
      A  = $urandom;
      if ($urandom_range(0, 1) == 1) A[31:8] = 24'h0;
      WD = $urandom;
      #1;
      check("rand_pre_edge", model[widx(A)]);
      @(posedge clk); #1;
      if (WE) model[widx(A)] = WD;
      check("rand_post_edge", model[widx(A)]);
      $display("rand %0d we=%0b A=0x%08h WD=0x%08h RD=0x%08h", n, WE, A, WD, RD);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
